// File: rtl/rc5_manchester_tx_if.sv
// Signal bundle between the RC-5 frame source (master) and the transmitter (slave).
// Build option RC5_CARRIER_EN has no effect on this bundle.
interface rc5_manchester_tx_if;
    // No valid/ready pair here. load is a level from the frame-rate divider,
    // and each 0->1 edge asks for one frame. toggle/address/command must be
    // stable in the cycle that edge is seen. An edge that arrives while a
    // frame is in flight is dropped and reported on overrun, except on the
    // done cycle, where it starts the next frame with no gap.
    logic       load;
    logic       toggle;
    logic [4:0] address;
    logic [5:0] command;
    logic       ir_out;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       state_dbg;

    modport master (
        output load, toggle, address, command,
        input  ir_out, busy, done, overrun, state_dbg
    );

    modport slave (
        input  load, toggle, address, command,
        output ir_out, busy, done, overrun, state_dbg
    );
endinterface

// File: rtl/rc5_manchester_tx.sv
// RC-5 14-bit frame transmitter with Manchester encoding on a registered IR drive.
// Define RC5_CARRIER_EN to gate marks with the carrier; otherwise ir_out is the baseband envelope.
module rc5_manchester_tx #(
    parameter int HALF_BIT_CYCLES = 88900,
    parameter int CARRIER_PERIOD  = 2778,
    parameter int CARRIER_HIGH    = 926
) (
    input  logic              clk,
    input  logic              rst,
    rc5_manchester_tx_if.slave bus
);
    localparam int CW = $clog2(HALF_BIT_CYCLES);
    localparam logic [CW-1:0] HB_LAST = CW'(HALF_BIT_CYCLES - 1);

    if (HALF_BIT_CYCLES < 2) begin : g_bad_half_bit
        $error("HALF_BIT_CYCLES must be at least 2");
    end
    if (CARRIER_HIGH >= CARRIER_PERIOD) begin : g_bad_carrier
        $error("CARRIER_HIGH must be less than CARRIER_PERIOD");
    end

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t          state, state_n;
    logic            load_q;
    logic [13:0]     frame, frame_n;
    logic [3:0]      bit_idx, bit_n;
    logic            half, half_n;
    logic [CW-1:0]   hb_cnt, cnt_n;
    logic            ir_q, ir_n;
    logic            ov_q, ov_n;
    logic            trigger, hb_term, frame_end, start, mark_n;

`ifdef RC5_CARRIER_EN
    localparam int KW = $clog2(CARRIER_PERIOD);
    localparam logic [KW-1:0] CAR_LAST = KW'(CARRIER_PERIOD - 1);
    localparam logic [KW-1:0] CAR_HIGH = KW'(CARRIER_HIGH);
    logic [KW-1:0] car_cnt, car_n;
`endif

    assign trigger   = bus.load & ~load_q;
    assign hb_term   = (hb_cnt == HB_LAST);
    assign frame_end = (state == SEND) && hb_term && half && (bit_idx == 4'd0);

    always_comb begin
        state_n = state;
        frame_n = frame;
        bit_n   = bit_idx;
        half_n  = half;
        cnt_n   = hb_cnt;
        start   = 1'b0;
        ov_n    = 1'b0;
        if (state == IDLE) begin
            start = trigger;
        end else begin
            ov_n = trigger && !frame_end;
            if (hb_term) begin
                cnt_n = '0;
                if (!half) begin
                    half_n = 1'b1;
                end else begin
                    half_n = 1'b0;
                    if (bit_idx == 4'd0) begin
                        // A start edge on the last cycle chains straight into the next frame.
                        if (trigger) start = 1'b1;
                        else         state_n = IDLE;
                    end else begin
                        bit_n = bit_idx - 4'd1;
                    end
                end
            end else begin
                cnt_n = hb_cnt + 1'b1;
            end
        end
        if (start) begin
            state_n = SEND;
            frame_n = {2'b11, bus.toggle, bus.address, bus.command};
            bit_n   = 4'd13;
            half_n  = 1'b0;
            cnt_n   = '0;
        end
        // First half of a bit is the inverse of the bit, second half is the bit itself.
        mark_n = half_n ? frame_n[bit_n] : ~frame_n[bit_n];
`ifdef RC5_CARRIER_EN
        car_n = '0;
        if (state_n == SEND && !start) begin
            car_n = (car_cnt == CAR_LAST) ? '0 : car_cnt + 1'b1;
        end
        ir_n = (state_n == SEND) && mark_n && (car_n < CAR_HIGH);
`else
        ir_n = (state_n == SEND) && mark_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            load_q  <= 1'b1;
            frame   <= '0;
            bit_idx <= '0;
            half    <= 1'b0;
            hb_cnt  <= '0;
            ir_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state   <= state_n;
            load_q  <= bus.load;
            frame   <= frame_n;
            bit_idx <= bit_n;
            half    <= half_n;
            hb_cnt  <= cnt_n;
            ir_q    <= ir_n;
            ov_q    <= ov_n;
        end
    end

`ifdef RC5_CARRIER_EN
    always_ff @(posedge clk) begin
        if (rst) car_cnt <= '0;
        else     car_cnt <= car_n;
    end
`endif

    assign bus.ir_out    = ir_q;
    assign bus.busy      = (state == SEND);
    assign bus.done      = frame_end;
    assign bus.overrun   = ov_q;
    assign bus.state_dbg = state;
endmodule

// File: doc/rc5_manchester_tx.md
Name: rc5_manchester_tx

Overview:
- RC-5 frame transmitter stage, directly downstream of the frame-rate load-strobe generator (the `load` input is that divider's output).
- On each rising edge of `load` it captures toggle/address/command and shifts out a 14-bit RC-5 frame, Manchester-encoded at 889 us per half-bit (88 900 clocks at 100 MHz).
- Drives the IR LED driver output; optionally gates marks with a 36 kHz carrier.

Parameters:
- HALF_BIT_CYCLES, 88900, clocks per Manchester half-bit (at least 2).
- CARRIER_PERIOD, 2778, clocks per carrier cycle (used only with the carrier feature).
- CARRIER_HIGH, 926, carrier high clocks per period (less than CARRIER_PERIOD).

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset, synchronous, active-high.
- load  input  1  frame strobe level from the load-strobe generator; a rising edge starts a frame.
- toggle  input  1  RC-5 toggle bit; sampled at frame start.
- address  input  5  RC-5 address, MSB first; sampled at frame start.
- command  input  6  RC-5 command, MSB first; sampled at frame start.
- ir_out  output  1  registered IR drive; 1 = mark (burst).
- busy  output  1  high while a frame is being sent.
- done  output  1  one-cycle pulse on the last cycle of a frame.
- overrun  output  1  one-cycle pulse when a start edge arrives while busy and is dropped.

Behaviour:
- Start detection:
  - load_q holds the previous-cycle value of `load`; it resets to 1, so the strobe's reset-high level causes no spurious start.
  - A trigger fires in a cycle where load=1 and load_q=0.
- Frame register, 14 bits, captured on trigger: {1, 1, toggle, address[4:0], command[5:0]}, sent MSB first.
- FSM has 2 states: IDLE, SEND.
  - IDLE + trigger -> SEND. Capture the frame; set bit_idx=13, half=0, hb_cnt=0.
  - SEND: hb_cnt counts 0..HALF_BIT_CYCLES-1.
    - At terminal count with half=0: set half=1.
    - At terminal count with half=1: set half=0 and decrement bit_idx.
    - At terminal count with half=1 and bit_idx=0: the frame ends. Pulse done and go to IDLE.
- Manchester encoding (mark level per half):
  - Bit 1: half0 = 0, half1 = 1.
  - Bit 0: half0 = 1, half1 = 0.
  - Mark level = half ? bit : ~bit.
- Latency:
  - A trigger seen in cycle N gives busy=1 and ir_out = first half-bit level from cycle N+1.
  - Each half-bit lasts exactly HALF_BIT_CYCLES cycles.
  - The frame lasts 28*HALF_BIT_CYCLES cycles.
  - done is high in the last frame cycle. From the following cycle, ir_out=0 and busy=0.
- Frame-length constraint: the strobe period must exceed 28*HALF_BIT_CYCLES. The nominal 11 379 000 > 2 489 200.
- Trigger during SEND, not on the end cycle: ignore it, pulse overrun, and leave the frame undisturbed.
- Trigger on the frame-end cycle:
  - done pulses and the new frame starts immediately: FSM stays in SEND and the fields are recaptured.
  - No overrun; busy stays 1.
- Input changes mid-frame have no effect; the fields are sampled only at the trigger.
- Reset values: ir_out=0, busy=0, done=0, overrun=0, FSM=IDLE, counters=0, load_q=1.
  - Reset mid-frame aborts the frame; ir_out=0 from the next cycle.
- Counter width: hb_cnt is wide enough for HALF_BIT_CYCLES-1 (17 bits at default); no wrap beyond terminal count.

Optional Feature:
- Macro: RC5_CARRIER_EN.
- Defined:
  - A carrier counter runs 0..CARRIER_PERIOD-1 while busy and restarts at 0 on every trigger.
  - carrier = (cnt < CARRIER_HIGH).
  - ir_out = mark & carrier, registered.
  - Carrier counter is held at 0 in IDLE.
- Not defined: ir_out = mark (baseband envelope); no carrier logic is synthesised.

Test Plan (HALF_BIT_CYCLES=4, CARRIER_PERIOD=6, CARRIER_HIGH=2 in simulation):
- Basic frame: rst for 3 cycles, then toggle=0, address=5'h05, command=6'h35, load rising edge.
  - Required ir_out half-bit sequence, 4 cycles each: 01 01 10 10 10 01 10 01 01 01 10 01 10 01.
  - busy high for 112 cycles; done pulses on cycle 112.
- Reset-level strobe: hold load=1 through and after reset -> no frame; busy stays 0 until load goes 0 then 1.
- Overrun: second load edge at cycle 50 of a frame -> overrun pulses once; the frame completes bit-exact; no second frame.
- Back-to-back: load edge on the frame's done cycle -> next frame's first half-bit starts the following cycle; busy never drops; no overrun.
- Reset mid-frame: rst asserted at cycle 30 -> ir_out=0, busy=0 next cycle; a new trigger afterwards produces a complete, correct frame.
- With RC5_CARRIER_EN: same stimulus as the basic frame -> during mark half-bits ir_out follows the pattern 110000 restarting at the trigger; during spaces ir_out=0.
